vector_plot_writer: RTL and testbench

//  Write-side client of the framebuffer dual-port RAM. Accepts pixel plot requests from the vector

---
 rtl/vector_plot_writer.sv | 154 +++++++++++++++
 tb/tb_vector_plot_writer.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_plot_writer.sv
// vector_plot_writer: framebuffer write-port client.
// Buffers pixel plots in a small FIFO and merges each one into the RAM
// with a max-intensity read-modify-write. A decay sweep, requested once
// per frame, fades every visible pixel.
module vector_plot_writer #(
  parameter int unsigned XW         = 8,
  parameter int unsigned YW         = 7,
  parameter int unsigned ZW         = 4,
  parameter int unsigned Y_LINES    = 96,
  parameter int unsigned DECAY      = 3,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             plot_valid,
  output logic             plot_ready,
  input  logic [XW-1:0]    plot_x,
  input  logic [YW-1:0]    plot_y,
  input  logic [ZW-1:0]    plot_z,
  input  logic             frame_start,
  output logic             sweep_busy,
  output logic [7:0]       drop_count,
  output logic [XW+YW-1:0] mem_address,
  output logic [ZW-1:0]    mem_data,
  output logic             mem_wren,
  input  logic [ZW-1:0]    mem_q
);

  localparam int unsigned AW = XW + YW;
  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam logic [AW-1:0] LAST_ADDR = {YW'(Y_LINES - 1), {XW{1'b1}}};
  localparam logic [CW-1:0] FULL      = CW'(FIFO_DEPTH);

  typedef struct packed {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [ZW-1:0] z;
  } plot_t;

  typedef enum logic [2:0] {IDLE, P_RD, P_WR, S_RD, S_WR} state_t;

  state_t        state, state_n;
  plot_t         fifo_mem [FIFO_DEPTH];
  plot_t         head;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_n;
  logic [ZW-1:0] z_reg, z_n;
  logic [AW-1:0] addr_n;
  logic          sweep_pending;
  logic          take_sweep, pop, accept, drop, push;

  assign accept  = plot_valid && plot_ready;
  assign drop    = accept && (32'(plot_y) >= Y_LINES);
  assign push    = accept && !drop;
  assign head    = fifo_mem[rd_ptr];
  assign count_n = count + CW'(push) - CW'(pop);

  // FIFO storage; no reset needed, occupancy is tracked separately
  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr] <= '{x: plot_x, y: plot_y, z: plot_z};
  end

  // FIFO pointers, occupancy and registered ready
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      plot_ready <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count      <= count_n;
      plot_ready <= (count_n != FULL);
    end
  end

  // One-deep sweep request; pulses while already pending are merged
  always_ff @(posedge clock or posedge reset) begin
    if (reset)            sweep_pending <= 1'b0;
    else if (take_sweep)  sweep_pending <= 1'b0;
    else if (frame_start) sweep_pending <= 1'b1;
  end

  // Saturating count of clipped plots
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                           drop_count <= '0;
    else if (drop && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
  end

  // State, RAM address and latched plot intensity
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      mem_address <= '0;
      z_reg       <= '0;
    end else begin
      state       <= state_n;
      mem_address <= addr_n;
      z_reg       <= z_n;
    end
  end

  // Next state: sweep wins at IDLE, a started plot always finishes
  always_comb begin
    state_n    = state;
    addr_n     = mem_address;
    z_n        = z_reg;
    take_sweep = 1'b0;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (sweep_pending) begin
          state_n    = S_RD;
          addr_n     = '0;
          take_sweep = 1'b1;
        end else if (count != '0) begin
          state_n = P_RD;
          addr_n  = {head.y, head.x};
          z_n     = head.z;
        end
      end
      P_RD: begin
        pop     = 1'b1;
        state_n = P_WR;
      end
      P_WR: state_n = IDLE;
      S_RD: state_n = S_WR;
      S_WR: begin
        if (mem_address == LAST_ADDR) begin
          state_n = IDLE;
        end else begin
          addr_n  = mem_address + AW'(1);
          state_n = S_RD;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Write-port outputs decoded from state; write data merges the read-back word
  always_comb begin
    mem_wren   = (state == P_WR) || (state == S_WR);
    sweep_busy = (state == S_RD) || (state == S_WR);
    mem_data   = '0;
    if (state == P_WR) begin
      mem_data = (mem_q > z_reg) ? mem_q : z_reg;
    end else if (state == S_WR) begin
      mem_data = (mem_q > ZW'(DECAY)) ? mem_q - ZW'(DECAY) : '0;
    end
  end

endmodule

// File: tb/tb_vector_plot_writer.sv
// Bench for vector_plot_writer: a RAM on the write port, a pixel-level
// model of the framebuffer, table vectors, random plots and sweep/reset sequences.
module tb_vector_plot_writer;

  localparam int NPIX       = 1 << 15;
  localparam int SWEEP_PIX  = 96 * 256;
  localparam int SWEEP_CYC  = 2 * SWEEP_PIX;

  logic        clock;
  logic        reset;
  logic        plot_valid;
  logic        plot_ready;
  logic [7:0]  plot_x;
  logic [6:0]  plot_y;
  logic [3:0]  plot_z;
  logic        frame_start;
  logic        sweep_busy;
  logic [7:0]  drop_count;
  logic [14:0] mem_address;
  logic [3:0]  mem_data;
  logic        mem_wren;
  logic [3:0]  mem_q;

  vector_plot_writer dut (
    .clock       (clock),
    .reset       (reset),
    .plot_valid  (plot_valid),
    .plot_ready  (plot_ready),
    .plot_x      (plot_x),
    .plot_y      (plot_y),
    .plot_z      (plot_z),
    .frame_start (frame_start),
    .sweep_busy  (sweep_busy),
    .drop_count  (drop_count),
    .mem_address (mem_address),
    .mem_data    (mem_data),
    .mem_wren    (mem_wren),
    .mem_q       (mem_q)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_total = 0;
  int n_bad   = 0;

  function automatic void check(input string name, input int act, input int exp);
    n_total++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  function automatic logic [3:0] decay(input logic [3:0] v);
    return (v > 4'd3) ? v - 4'd3 : 4'd0;
  endfunction

  // Framebuffer RAM, port A; the bench can clear it or poke one word
  logic [3:0]  ram [NPIX];
  logic        clr, pl_en;
  logic [14:0] pl_addr;
  logic [3:0]  pl_data;

  always @(posedge clock) begin
    if (clr) begin
      for (int i = 0; i < NPIX; i++) ram[i] <= 4'd0;
    end else if (pl_en) begin
      ram[pl_addr] <= pl_data;
    end else if (mem_wren) begin
      ram[mem_address] <= mem_data;
    end
    mem_q <= ram[mem_address];
  end

  // Reference: expected pixel values, queue of accepted plots, drop count
  typedef struct {
    logic [7:0] x;
    logic [6:0] y;
    logic [3:0] z;
  } pl_t;

  logic [3:0]  model [NPIX];
  pl_t         exp_q [$];
  int          exp_drops = 0;
  int          sw_idx = 0;
  int          sw_bad = 0;
  int          busy_len = 0;
  int          last_busy_len = 0;
  logic        prev_busy = 1'b0;
  pl_t         mp;
  logic [14:0] ma;
  logic [3:0]  me;

  always @(negedge clock) begin
    if (clr) for (int i = 0; i < NPIX; i++) model[i] = 4'd0;
    if (pl_en) model[pl_addr] = pl_data;
    if (reset) begin
      exp_q.delete();
      exp_drops = 0;
      prev_busy = 1'b0;
    end else begin
      if (plot_valid && plot_ready) begin
        if (int'(plot_y) >= 96) begin
          if (exp_drops < 255) exp_drops++;
        end else begin
          exp_q.push_back('{plot_x, plot_y, plot_z});
        end
      end
      if (sweep_busy && !prev_busy) begin
        sw_idx   = 0;
        busy_len = 0;
      end
      if (sweep_busy) busy_len++;
      if (!sweep_busy && prev_busy) last_busy_len = busy_len;
      if (mem_wren) begin
        if (sweep_busy) begin
          if (int'(mem_address) != sw_idx || mem_data != decay(model[15'(sw_idx)])) sw_bad++;
          if (sw_idx < NPIX) model[15'(sw_idx)] = decay(model[15'(sw_idx)]);
          sw_idx++;
        end else if (exp_q.size() == 0) begin
          check("unexpected_plot_write", 1, 0);
        end else begin
          mp = exp_q.pop_front();
          ma = {mp.y, mp.x};
          me = (model[ma] > mp.z) ? model[ma] : mp.z;
          check("plot_write_addr", int'(mem_address), int'(ma));
          check("plot_write_data", int'(mem_data), int'(me));
          model[ma] = me;
        end
      end
      prev_busy = sweep_busy;
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic preload(input logic [14:0] a, input logic [3:0] d);
    pl_addr = a;
    pl_data = d;
    pl_en   = 1'b1;
    step();
    pl_en   = 1'b0;
  endtask

  task automatic send_plot(input logic [7:0] x, input logic [6:0] y, input logic [3:0] z,
                           input int limit, output bit ok);
    plot_x = x;
    plot_y = y;
    plot_z = z;
    plot_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < limit && !ok; i++) begin
      @(negedge clock);
      if (plot_ready) ok = 1'b1;
    end
    step();
    plot_valid = 1'b0;
  endtask

  task automatic wait_write(input int limit, output bit found, output logic [14:0] addr,
                            output logic [3:0] data, output logic pwren, output logic [14:0] paddr);
    found = 1'b0;
    addr  = '0;
    data  = '0;
    pwren = 1'b1;
    paddr = '0;
    for (int i = 0; i < limit && !found; i++) begin
      @(negedge clock);
      if (mem_wren && !sweep_busy) begin
        found = 1'b1;
        addr  = mem_address;
        data  = mem_data;
      end else begin
        pwren = mem_wren;
        paddr = mem_address;
      end
    end
    step();
  endtask

  task automatic wait_busy(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 5 && !seen; i++) begin
      @(negedge clock);
      if (sweep_busy) seen = 1'b1;
    end
    step();
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) step();
    repeat (4) step();
  endtask

  typedef struct {
    logic [7:0]  x;
    logic [6:0]  y;
    logic [3:0]  z;
    logic        pl;
    logic [3:0]  pre;
    logic        wr;
    logic [14:0] a;
    logic [3:0]  d;
    int          drops;
  } vec_t;

  vec_t tbl [8];

  initial begin : watchdog
    #1500000;
    $display("FAIL watchdog: run exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    bit          ok, found, seen;
    logic [14:0] wa, pa;
    logic [3:0]  wd;
    logic        pw;
    int          nb;

    tbl[0] = '{8'd5,   7'd3,   4'd9,  1'b1, 4'd0, 1'b1, 15'h0305, 4'd9,  0};
    tbl[1] = '{8'h20,  7'h10,  4'd4,  1'b1, 4'd7, 1'b1, 15'h1020, 4'd7,  0};
    tbl[2] = '{8'h20,  7'h10,  4'd12, 1'b0, 4'd0, 1'b1, 15'h1020, 4'd12, 0};
    tbl[3] = '{8'hFF,  7'd95,  4'd15, 1'b1, 4'd3, 1'b1, 15'h5FFF, 4'd15, 0};
    tbl[4] = '{8'd0,   7'd0,   4'd0,  1'b1, 4'd5, 1'b1, 15'h0000, 4'd5,  0};
    tbl[5] = '{8'd1,   7'd96,  4'd5,  1'b0, 4'd0, 1'b0, 15'h0000, 4'd0,  1};
    tbl[6] = '{8'h7F,  7'd127, 4'd1,  1'b0, 4'd0, 1'b0, 15'h0000, 4'd0,  2};
    tbl[7] = '{8'hAA,  7'h55,  4'd6,  1'b1, 4'd6, 1'b1, 15'h55AA, 4'd6,  2};

    reset = 1'b1; clr = 1'b1; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    plot_valid = 1'b0; plot_x = '0; plot_y = '0; plot_z = '0; frame_start = 1'b0;
    repeat (3) step();
    @(negedge clock);
    check("reset_plot_ready", int'(plot_ready), 1);
    check("reset_sweep_busy", int'(sweep_busy), 0);
    check("reset_drop_count", int'(drop_count), 0);
    check("reset_mem_address", int'(mem_address), 0);
    check("reset_mem_data", int'(mem_data), 0);
    check("reset_mem_wren", int'(mem_wren), 0);
    step();
    clr = 1'b0;
    reset = 1'b0;
    step();

    // Directed plot vectors
    for (int i = 0; i < 8; i++) begin
      if (tbl[i].pl) preload({tbl[i].y, tbl[i].x}, tbl[i].pre);
      send_plot(tbl[i].x, tbl[i].y, tbl[i].z, 10, ok);
      check($sformatf("vec%0d_accept", i), int'(ok), 1);
      wait_write(tbl[i].wr ? 10 : 6, found, wa, wd, pw, pa);
      check($sformatf("vec%0d_written", i), int'(found), int'(tbl[i].wr));
      if (tbl[i].wr && found) begin
        check($sformatf("vec%0d_read_addr", i), int'(pa), int'(tbl[i].a));
        check($sformatf("vec%0d_read_wren", i), int'(pw), 0);
        check($sformatf("vec%0d_write_addr", i), int'(wa), int'(tbl[i].a));
        check($sformatf("vec%0d_write_data", i), int'(wd), int'(tbl[i].d));
      end
      check($sformatf("vec%0d_drop_count", i), int'(drop_count), tbl[i].drops);
    end

    // Random plots on a small patch so repeated pixels and back-pressure occur
    for (int c = 0; c < 2000; c++) begin
      plot_valid = ($urandom_range(0, 1) == 1);
      plot_x = 8'($urandom_range(0, 2));
      if ($urandom_range(0, 7) == 0) plot_y = 7'($urandom_range(96, 127));
      else plot_y = 7'($urandom_range(0, 2));
      plot_z = 4'($urandom());
      step();
    end
    plot_valid = 1'b0;
    drain();
    check("rand_drained", exp_q.size(), 0);
    check("rand_drop_count", int'(drop_count), exp_drops);

    // Full decay sweep with plots held back behind it
    preload(15'h0A0A, 4'd2);
    preload(15'h0B0B, 4'd10);
    sw_bad = 0;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    wait_busy(seen);
    check("sweep_started", int'(seen), 1);
    for (int k = 0; k < 6; k++) begin
      send_plot(8'(40 + k), 7'd20, 4'(k + 1), 60000, ok);
      check($sformatf("hold_accept%0d", k), int'(ok), 1);
      if (k == 3) begin
        @(negedge clock);
        check("hold_ready_full", int'(plot_ready), 0);
        check("hold_still_busy", int'(sweep_busy), 1);
        step();
      end
    end
    drain();
    check("sweep_busy_cycles", last_busy_len, SWEEP_CYC);
    check("sweep_write_count", sw_idx, SWEEP_PIX);
    check("sweep_bad_writes", sw_bad, 0);
    check("sweep_pixel_2", int'(ram[15'h0A0A]), 0);
    check("sweep_pixel_10", int'(ram[15'h0B0B]), 7);
    check("hold_drained", exp_q.size(), 0);

    // Reset in the middle of a sweep with a full FIFO
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    wait_busy(seen);
    check("sweep2_started", int'(seen), 1);
    repeat (300) step();
    for (int k = 0; k < 4; k++) begin
      send_plot(8'(60 + k), 7'd30, 4'd9, 5, ok);
      check($sformatf("abort_accept%0d", k), int'(ok), 1);
    end
    reset = 1'b1;
    #1;
    check("abort_plot_ready", int'(plot_ready), 1);
    check("abort_sweep_busy", int'(sweep_busy), 0);
    check("abort_drop_count", int'(drop_count), 0);
    check("abort_mem_address", int'(mem_address), 0);
    check("abort_mem_data", int'(mem_data), 0);
    check("abort_mem_wren", int'(mem_wren), 0);
    step();
    step();
    reset = 1'b0;
    step();
    seen = 1'b0;
    repeat (5) begin
      @(negedge clock);
      if (sweep_busy) seen = 1'b1;
    end
    step();
    check("abort_no_resweep", int'(seen), 0);
    preload(15'h0703, 4'd2);
    send_plot(8'd3, 7'd7, 4'd5, 10, ok);
    check("post_reset_accept", int'(ok), 1);
    wait_write(10, found, wa, wd, pw, pa);
    check("post_reset_written", int'(found), 1);
    check("post_reset_addr", int'(wa), 16'h0703);
    check("post_reset_data", int'(wd), 5);

    // Drop counter saturation
    plot_valid = 1'b1;
    plot_x = 8'd0;
    plot_y = 7'd100;
    plot_z = 4'd1;
    repeat (300) step();
    plot_valid = 1'b0;
    step();
    check("drop_saturated", int'(drop_count), 255);

    // Whole framebuffer against the model
    nb = 0;
    for (int i = 0; i < NPIX; i++) if (ram[i] !== model[i]) nb++;
    check("ram_vs_model", nb, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
